// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM carrier path:
// carrier width, mode codes and triangle direction states.
package pwm_pkg;

    localparam int ANCHO_PWM = 10;

    localparam logic MODO_DIENTE = 1'b0;
    localparam logic MODO_TRIANG = 1'b1;

    typedef enum logic {
        SUBE = 1'b0,
        BAJA = 1'b1
    } dir_t;

endpackage

// File: rtl/generador_portadora_if.sv
// Control/load and comparator-side signals of the carrier generator.
// The slave side is the generator; the master side is its controller.
interface generador_portadora_if #(
    parameter int ANCHO = pwm_pkg::ANCHO_PWM
);

    logic             Habilitar;
    logic             Modo_In;
    logic [ANCHO-1:0] Periodo_In;
    logic [ANCHO-1:0] Ref_In;
    logic             Cargar;
    logic             Pendiente;
    logic             Listo;
    logic             Fin_Periodo;
    logic [ANCHO-1:0] Frec_Conm;
    logic [ANCHO-1:0] Corri_Ref;

    modport master (
        output Habilitar,
        output Modo_In,
        output Periodo_In,
        output Ref_In,
        output Cargar,
        input  Pendiente,
        input  Listo,
        input  Fin_Periodo,
        input  Frec_Conm,
        input  Corri_Ref
    );

    modport slave (
        input  Habilitar,
        input  Modo_In,
        input  Periodo_In,
        input  Ref_In,
        input  Cargar,
        output Pendiente,
        output Listo,
        output Fin_Periodo,
        output Frec_Conm,
        output Corri_Ref
    );

endinterface

// File: rtl/contador_portadora.sv
// Carrier counter with sawtooth/triangle direction FSM.
// limite flags the last count of the current carrier period.
module contador_portadora
    import pwm_pkg::*;
#(
    parameter int ANCHO = ANCHO_PWM
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             habilitar,
    input  logic             modo,
    input  logic [ANCHO-1:0] top,
    output logic [ANCHO-1:0] count,
    output logic             limite
);

    dir_t dir;

    // A triangle with top<=1 has no falling leg, so the peak ends the period
    always_comb begin
        limite = 1'b0;
        if (top == '0) begin
            limite = 1'b1;
        end else if (modo == MODO_DIENTE) begin
            limite = (count == top);
        end else if (dir == SUBE) begin
            limite = (count == top) && (top <= ANCHO'(1));
        end else begin
            limite = (count == ANCHO'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            dir   <= SUBE;
        end else if (habilitar) begin
            if (limite) begin
                count <= '0;
                dir   <= SUBE;
            end else if (modo == MODO_DIENTE) begin
                count <= count + ANCHO'(1);
            end else if (dir == SUBE && count == top) begin
                count <= top - ANCHO'(1);
                dir   <= BAJA;
            end else if (dir == SUBE) begin
                count <= count + ANCHO'(1);
            end else begin
                count <= count - ANCHO'(1);
            end
        end
    end

endmodule

// File: rtl/generador_portadora.sv
// PWM carrier generator: double-buffered period/reference/mode
// that take effect only when a new carrier period starts.
module generador_portadora
    import pwm_pkg::*;
#(
    parameter int ANCHO       = ANCHO_PWM,
    parameter int PERIODO_RST = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    generador_portadora_if.slave bus
);

    logic [ANCHO-1:0] top_q;
    logic [ANCHO-1:0] ref_q;
    logic             modo_q;
    logic [ANCHO-1:0] s_top;
    logic [ANCHO-1:0] s_ref;
    logic             s_modo;
    logic             pend_q;
    logic             listo_q;
    logic             fin_q;
    logic [ANCHO-1:0] count;
    logic             limite;
    logic             avance;

    contador_portadora #(
        .ANCHO(ANCHO)
    ) u_contador (
        .clk      (clk),
        .reset    (reset),
        .habilitar(bus.Habilitar),
        .modo     (modo_q),
        .top      (top_q),
        .count    (count),
        .limite   (limite)
    );

    assign avance = bus.Habilitar & limite;

    // Staging applied on a boundary is the pre-edge copy; a coincident
    // load is captured and stays pending for the following period
    always_ff @(posedge clk) begin
        if (reset) begin
            top_q   <= ANCHO'(PERIODO_RST);
            ref_q   <= '0;
            modo_q  <= MODO_DIENTE;
            s_top   <= '0;
            s_ref   <= '0;
            s_modo  <= MODO_DIENTE;
            pend_q  <= 1'b0;
            listo_q <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            fin_q   <= avance;
            listo_q <= avance & pend_q;
            if (avance && pend_q) begin
                top_q  <= s_top;
                ref_q  <= s_ref;
                modo_q <= s_modo;
            end
            if (bus.Cargar) begin
                s_top  <= bus.Periodo_In;
                s_ref  <= bus.Ref_In;
                s_modo <= bus.Modo_In;
                pend_q <= 1'b1;
            end else if (avance) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign bus.Pendiente   = pend_q;
    assign bus.Listo       = listo_q;
    assign bus.Fin_Periodo = fin_q;
    assign bus.Frec_Conm   = count;
    assign bus.Corri_Ref   = ref_q;

endmodule

// File: tb/tb_generador_portadora.sv
// Randomised and directed bench for generador_portadora against
// a period/phase model of the carrier and double-buffered loads.
module tb_generador_portadora;

    localparam int W = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    generador_portadora_if #(.ANCHO(W)) bus();

    generador_portadora #(
        .ANCHO      (W),
        .PERIODO_RST(1023)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int vectors = 0;
    int errors  = 0;

    // Model: active/staged values plus phase index inside the period
    int m_top, m_ref, m_pos, s_top, s_ref;
    bit m_modo, s_modo, m_pend, m_listo, m_fin;

    function automatic int m_len();
        if (m_top == 0) return 1;
        return m_modo ? 2 * m_top : m_top + 1;
    endfunction

    function automatic int m_count();
        if (!m_modo || m_pos <= m_top) return m_pos;
        return 2 * m_top - m_pos;
    endfunction

    function automatic logic [2*W+2:0] expv();
        logic [W-1:0] c;
        logic [W-1:0] r;
        c = W'(m_count());
        r = W'(m_ref);
        return {m_pend, m_listo, m_fin, c, r};
    endfunction

    function automatic logic [2*W+2:0] gotv();
        return {bus.Pendiente, bus.Listo, bus.Fin_Periodo,
                bus.Frec_Conm, bus.Corri_Ref};
    endfunction

    task automatic step(input bit r, input bit h, input bit c,
                        input bit m, input int p, input int rf);
        bit b;
        reset          = r;
        bus.Habilitar  = h;
        bus.Cargar     = c;
        bus.Modo_In    = m;
        bus.Periodo_In = W'(p);
        bus.Ref_In     = W'(rf);
        @(posedge clk);
        if (r) begin
            m_top = 1023; m_ref = 0; m_modo = 0; m_pos = 0;
            m_pend = 0; m_listo = 0; m_fin = 0;
            s_top = 0; s_ref = 0; s_modo = 0;
        end else begin
            b = h && (m_pos == m_len() - 1);
            m_fin   = b;
            m_listo = b && m_pend;
            if (b) begin
                m_pos = 0;
                if (m_pend) begin
                    m_top = s_top; m_ref = s_ref; m_modo = s_modo;
                end
            end else if (h) begin
                m_pos++;
            end
            if (c) begin
                s_top = p; s_ref = rf; s_modo = m; m_pend = 1;
            end else if (b) begin
                m_pend = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 0, 0);
            vectors++;
            if (gotv() !== 23'h0) begin
                errors++;
                $display("FAIL reset got %h want 0", gotv());
            end
        end
    endtask

    task automatic test_default_saw();
        int fins = 0;
        for (int i = 0; i < 2100; i++) begin
            step(0, 1, 0, 0, 0, 0);
            if (bus.Fin_Periodo === 1'b1) fins++;
            vectors++;
            if (gotv() !== expv()) begin
                errors++;
                $display("FAIL default_saw i=%0d got %h want %h",
                         i, gotv(), expv());
            end
        end
        vectors++;
        if (fins !== 2) begin
            errors++;
            $display("FAIL default_fin_count got %0d want 2", fins);
        end
    endtask

    task automatic test_load_saw();
        step(0, 1, 1, 0, 4, 2);
        vectors++;
        if (bus.Pendiente !== 1'b1) begin
            errors++;
            $display("FAIL load_pend got %b want 1", bus.Pendiente);
        end
        for (int i = 0; i < 1100; i++) begin
            step(0, 1, 0, 0, 0, 0);
            vectors++;
            if (gotv() !== expv()) begin
                errors++;
                $display("FAIL load_saw i=%0d got %h want %h",
                         i, gotv(), expv());
            end
        end
        vectors++;
        if (bus.Corri_Ref !== W'(2)) begin
            errors++;
            $display("FAIL load_ref got %0d want 2", bus.Corri_Ref);
        end
    endtask

    task automatic test_triangular();
        step(0, 1, 1, 1, 3, 1);
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 0, 0, 0, 0);
            vectors++;
            if (gotv() !== expv()) begin
                errors++;
                $display("FAIL triangular i=%0d got %h want %h",
                         i, gotv(), expv());
            end
        end
    endtask

    task automatic test_small_top();
        for (int t = 1; t >= 0; t--) begin
            step(0, 1, 1, 1, t, 9);
            for (int i = 0; i < 20; i++) begin
                step(0, 1, 0, 0, 0, 0);
                vectors++;
                if (gotv() !== expv()) begin
                    errors++;
                    $display("FAIL small_top t=%0d i=%0d got %h want %h",
                             t, i, gotv(), expv());
                end
            end
        end
    endtask

    task automatic test_last_write();
        int n;
        int listos = 0;
        step(0, 1, 1, 0, 6, 5);
        step(0, 1, 1, 0, 6, 7);
        n = 0;
        while (!(m_pos == m_len() - 1) && n < 100) begin
            step(0, 1, 0, 0, 0, 0);
            n++;
        end
        vectors++;
        if (n >= 100) begin
            errors++;
            $display("FAIL last_write_timeout got %0d want <100", n);
        end
        step(0, 1, 1, 0, 5, 3);
        vectors++;
        if (gotv() !== expv() || bus.Corri_Ref !== W'(7)
            || bus.Pendiente !== 1'b1) begin
            errors++;
            $display("FAIL last_write_boundary got %h want %h",
                     gotv(), expv());
        end
        for (int i = 0; i < 30; i++) begin
            step(0, 1, 0, 0, 0, 0);
            if (bus.Listo === 1'b1) listos++;
            vectors++;
            if (gotv() !== expv()) begin
                errors++;
                $display("FAIL last_write i=%0d got %h want %h",
                         i, gotv(), expv());
            end
        end
        vectors++;
        if (listos !== 1) begin
            errors++;
            $display("FAIL third_load_listo got %0d want 1", listos);
        end
    endtask

    task automatic test_random_enable();
        for (int i = 0; i < 3000; i++) begin
            step(0, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 9)),
                 int'($urandom_range(0, 1023)));
            vectors++;
            if (gotv() !== expv()) begin
                errors++;
                $display("FAIL random_enable i=%0d got %h want %h",
                         i, gotv(), expv());
            end
        end
    endtask

    task automatic test_reset_pending();
        step(0, 1, 1, 1, 2, 4);
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        vectors++;
        if (bus.Pendiente !== 1'b0 || gotv() !== expv()) begin
            errors++;
            $display("FAIL reset_pending got %h want %h", gotv(), expv());
        end
        for (int i = 0; i < 1100; i++) begin
            step(0, 1, 0, 0, 0, 0);
            vectors++;
            if (gotv() !== expv()) begin
                errors++;
                $display("FAIL reset_top i=%0d got %h want %h",
                         i, gotv(), expv());
            end
        end
    endtask

    initial begin
        bus.Habilitar  = 1'b0;
        bus.Cargar     = 1'b0;
        bus.Modo_In    = 1'b0;
        bus.Periodo_In = '0;
        bus.Ref_In     = '0;
        test_reset();
        test_default_saw();
        test_load_saw();
        test_triangular();
        test_small_top();
        test_last_write();
        test_random_enable();
        test_reset_pending();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule

// File: doc/generador_portadora.md
# generador_portadora

Carrier generator feeding the PWM comparator stage: it produces the carrier count `Frec_Conm` and the active reference `Corri_Ref` that the comparator compares. It supports sawtooth and triangular carriers with a programmable period. New period/reference/mode values are double-buffered and applied only at a carrier period boundary, so the comparator never sees a mid-period glitch.

## Interface
- `ANCHO`, 10, carrier/reference width.
- `PERIODO_RST`, 1023, active top value after reset.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `Habilitar`  in  1  count tick (prescaler enable); counter advances only when 1.
- `Modo_In`  in  1  requested mode: 0 sawtooth, 1 triangular.
- `Periodo_In`  in  ANCHO  requested top value.
- `Ref_In`  in  ANCHO  requested reference (duty).
- `Cargar`  in  1  load strobe; captures `Modo_In`/`Periodo_In`/`Ref_In` into staging.
- `Pendiente`  out  1  staged values are waiting for a boundary.
- `Listo`  out  1  one-cycle pulse: staged values have just become active.
- `Fin_Periodo`  out  1  one-cycle pulse: a new carrier period has started.
- `Frec_Conm`  out  ANCHO  carrier count to the comparator.
- `Corri_Ref`  out  ANCHO  active reference to the comparator.

## Operation
- Active registers: `top`, `ref`, `modo`, counter, direction state. Staging registers: `s_top`, `s_ref`, `s_modo`.
- `Cargar`=1: the staging registers take the inputs at the next edge and `Pendiente`<=1. This is independent of `Habilitar`. A repeated `Cargar` overwrites the staging registers (last write wins).
- Sawtooth sequence: 0,1,…,top, then 0. Period is top+1 ticks. The boundary is `count==top`.
- Triangular direction FSM has two states, SUBE and BAJA. Sequence: 0,1,…,top,top−1,…,1, then 0. Period is 2·top ticks.
  - In SUBE at `count==top`: go to BAJA, `count<=top−1`.
  - In BAJA at `count==1`: boundary.
  - If top≤1, SUBE at `count==top` is itself the boundary.
- top==0 in either mode: the counter holds 0 and every tick is a boundary.
- On a boundary with `Habilitar`=1:
  - `count<=0`, state<=SUBE.
  - If `Pendiente`=1, copy the staging registers into the active registers, set `Pendiente`<=0 and assert `Listo`.
  - The staging contents applied are those present before this edge. A `Cargar` in the same cycle is captured and stays pending for the next boundary.
- Because changes apply only when the count returns to 0, the count never exceeds the active top.
- `ref`>top gives 100 % duty and `ref`==0 gives 0 %. Both pass through unclamped.
- `Habilitar`=0 freezes the counter, FSM and outputs. Only staging capture continues.

## Timing
- All outputs are registered.
- Reset values: `Frec_Conm`=0, `Corri_Ref`=0, state SUBE, top=`PERIODO_RST`, modo=0, staging cleared, `Pendiente`=0, `Listo`=0, `Fin_Periodo`=0.
- `Frec_Conm` changes 1 cycle after a `Habilitar` sample.
- `Fin_Periodo` and `Listo` are high in the first cycle where `Frec_Conm`==0 of the new period, and in that cycle only. The new `Corri_Ref` is visible in that same cycle.
- `Pendiente` rises 1 cycle after `Cargar` and falls in the cycle `Listo` is high. If `Cargar` coincides with the boundary edge, `Pendiente` stays 1.
- Reset mid-period or mid-load discards staged values, and the counter restarts at 0 in SUBE.
- The block has no combinational path from inputs to outputs.

## Structure
- Shared package `pwm_pkg`:
  - `ANCHO_PWM` = 10.
  - `MODO_DIENTE` = 1'b0, `MODO_TRIANG` = 1'b1.
  - State encoding `SUBE` / `BAJA`.
- Sub-module `contador_portadora` holds the counter, direction FSM and boundary detection. Its inputs are top, modo and `Habilitar`; its outputs are count and boundary.
- `generador_portadora` holds the staging/active registers and the handshake outputs.

## Test plan
- Reset, then `Habilitar`=1 continuously with defaults → `Frec_Conm` steps 0…1023, wraps to 0. `Fin_Periodo` pulses every 1024 cycles. `Corri_Ref`=0.
- Load top=4, ref=2, mode 0 mid-period → `Pendiente`=1 until the wrap. Then `Listo` and `Fin_Periodo` pulse together, and the sequence is 0,1,2,3,4,0 with `Corri_Ref`=2 from the first 0.
- Load top=3, mode 1 → after the boundary the sequence is 0,1,2,3,2,1,0,1…, with `Fin_Periodo` every 6 cycles at count 0.
- Triangular with top=1 and top=0 → the sequence is 0,1,0,1 (period 2). For top=0 the count holds 0 and `Fin_Periodo` is high every enabled cycle.
- `Cargar` twice (ref=5, then ref=7) before the boundary → only 7 is applied and `Listo` pulses once. A third `Cargar` on the boundary cycle leaves `Pendiente`=1 for the next period.
- Toggle `Habilitar` 1/0 → the count advances only on enabled cycles. A reset asserted while `Pendiente`=1 → `Pendiente`=0 and top returns to 1023.
